ahbl_splitter_n: RTL and testbench
==================================

// Module: ahbl_splitter_n
// PURPOSE
//  Parametrised N-port AHB-Lite address splitter for the SoC bus fabric. Decodes HADDR[31:32-PAGE_W]
//  into one-hot slave selects, tracks the data-phase owner and muxes HREADY/HRESP/HRDATA back to the master.
//  Unlike the fixed 4-port splitter, it has an internal default slave: transfers to unmapped pages get an
//  AHB-Lite two-cycle ERROR response instead of silently completing.
// PARAMETERS
//  NS         4             number of slaves, 1..8
//  PAGE_W     4             HADDR MSBs used for decode (2^PAGE_W equal pages)
//  PAGES      {4'h8,4'h4,4'h2,4'h0}  packed NS*PAGE_W page IDs; slice [i*PAGE_W +: PAGE_W] maps to slave i
//  RDATA_DEF  32'hBADDBEEF  HRDATA driven when no slave owns the data phase
// PORTS
//  HCLK         in   1       bus clock
//  HRESETn      in   1       async active-low reset
//  HADDR        in   32      master address (address phase)
//  HTRANS       in   2       master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//  HREADY       out  1       bus ready to master and to every slave's HREADY input
//  HRESP        out  1       bus response to master (0 OKAY, 1 ERROR)
//  HRDATA       out  32      read data to master
//  S_HSEL       out  NS      one-hot slave selects (address phase, combinational)
//  S_HRDATA     in   NS*32   slave read data, slice i = slave i
//  S_HREADYOUT  in   NS      slave ready outputs
//  S_HRESP      in   NS      slave responses
// BEHAVIOUR
//  Decode: S_HSEL[i] = (HADDR page == PAGES slice i); duplicate page IDs resolve to the lowest index (one-hot
//   guaranteed). S_HSEL is driven regardless of HTRANS; slaves qualify with HTRANS/HREADY themselves.
//  miss = no S_HSEL bit set.
//  Data-phase owner sel_d [NS:0], one-hot or zero; bit NS = default slave:
//   - reset (async): sel_d = 0.
//   - on posedge HCLK with HREADY=1: sel_d <= HTRANS[1] ? {miss, S_HSEL} : 0.
//   - HREADY=0: sel_d holds.
//  Output mux from sel_d, zero added latency:
//   - slave i owns: HREADY = S_HREADYOUT[i]; HRESP = S_HRESP[i]; HRDATA = S_HRDATA slice i.
//   - none owns: HREADY=1, HRESP=0, HRDATA=RDATA_DEF.
//   - default slave owns: HREADY/HRESP from the default-slave FSM; HRDATA=RDATA_DEF.
//  Default-slave FSM states: IDLE, ERR1, ERR2; reset -> IDLE.
//   - IDLE: HREADY=1, HRESP=0. With HREADY=1, HTRANS[1]=1 and miss -> ERR1.
//   - ERR1: HREADY=0, HRESP=1 -> ERR2 unconditionally.
//   - ERR2: HREADY=1, HRESP=1. Next address phase is sampled here:
//     new NONSEQ/SEQ miss -> ERR1; otherwise -> IDLE.
//   - IDLE/BUSY to an unmapped page: no error, zero-wait OKAY.
//  Reset values: HREADY=1, HRESP=0, HRDATA=RDATA_DEF, FSM=IDLE. S_HSEL follows HADDR combinationally.
//  Reset asserted mid-transfer (incl. ERR1/ERR2 or slave wait): all state clears immediately;
//   no pending response is kept.
//  Back-to-back: slave i data phase overlapping the address phase of slave j is legal; sel_d switches
//   only on the HREADY=1 edge. A master cancel (HTRANS->IDLE) during ERR2 ends the error cleanly.
//  No combinational path from S_HREADYOUT to S_HSEL; the only HREADY feedback is into the sel_d/FSM enables.
// STRUCTURE
//  ahbl_pkg (shared): HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, RDATA_DEF default.
//  Sub-module ahbl_default_slave: the 3-state ERROR FSM.
//   Inputs: HCLK, HRESETn, sel (miss & HTRANS[1]), HREADY. Outputs: HREADYOUT, HRESP.
//  Top: decoder (priority loop over NS), sel_d register, output muxes (loop over NS, default-slave arm).
// TESTING
//  1. Reset: hold HRESETn=0 with random inputs -> HREADY=1, HRESP=0, HRDATA=32'hBADDBEEF.
//  2. NONSEQ read 0x2000_0010 then IDLE, S_HREADYOUT[1] low 2 cycles, S_HRDATA[1]=0x1234_5678
//     -> S_HSEL=4'b0010 in address phase; HREADY low 2 cycles; HRDATA=0x1234_5678 on completion.
//  3. NONSEQ to unmapped 0x3000_0000 -> HREADY=0,HRESP=1 for 1 cycle, then HREADY=1,HRESP=1 for 1 cycle,
//     then OKAY. BUSY to the same address -> zero-wait OKAY.
//  4. Back-to-back NONSEQ 0x0000_0000 -> 0x8000_0004 -> 0xF000_0000 -> 0x4000_0000
//     -> responses from S0, S3, ERROR, S2 in order; sel_d changes only on HREADY=1 edges.
//  5. Slave error: S_HRESP[2]=1 two-cycle pattern from slave 2 -> passed through unchanged on HRESP/HREADY.
//  6. Assert HRESETn=0 in ERR1 and during a slave-0 wait -> outputs reach reset values with no clock;
//     the first transfer after release decodes normally.

Source files
------------

// File: rtl/ahbl_splitter_n_pkg.sv
// ahbl_splitter_n_pkg: shared AHB-Lite encodings and default-slave state type
package ahbl_splitter_n_pkg;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ = 2'b11;
    localparam logic HRESP_OKAY = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam logic [31:0] RDATA_DEF_C = 32'hBADDBEEF;
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
endpackage

// File: rtl/ahbl_splitter_n_if.sv
// ahbl_splitter_n_if: master-side and slave-side AHB-Lite signals of the splitter
interface ahbl_splitter_n_if #(parameter int NS = 4);
    logic [31:0] HADDR;
    logic [1:0] HTRANS;
    logic HREADY;
    logic HRESP;
    logic [31:0] HRDATA;
    logic [NS-1:0] S_HSEL;
    logic [NS*32-1:0] S_HRDATA;
    logic [NS-1:0] S_HREADYOUT;
    logic [NS-1:0] S_HRESP;
    modport master (output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
                    input HREADY, HRESP, HRDATA, S_HSEL);
    modport slave (input HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
                   output HREADY, HRESP, HRDATA, S_HSEL);
endinterface

// File: rtl/ahbl_splitter_n_default_slave.sv
// ahbl_splitter_n_default_slave: two-cycle ERROR responder for unmapped pages
module ahbl_splitter_n_default_slave
    import ahbl_splitter_n_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic sel,
    input  logic HREADY,
    output logic HREADYOUT,
    output logic HRESP
);
    ds_state_t state, state_n;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= DS_IDLE;
        else state <= state_n;
    end
    always_comb begin
        HREADYOUT = state != DS_ERR1;
        HRESP = state == DS_IDLE ? HRESP_OKAY : HRESP_ERROR;
        state_n = state == DS_ERR1 ? DS_ERR2 : (HREADY && sel) ? DS_ERR1 : DS_IDLE;
    end
endmodule

// File: rtl/ahbl_splitter_n.sv
// ahbl_splitter_n: N-port AHB-Lite page decoder with response mux and default ERROR slave
module ahbl_splitter_n
    import ahbl_splitter_n_pkg::*;
#(
    parameter int NS = 4,
    parameter int PAGE_W = 4,
    parameter logic [NS*PAGE_W-1:0] PAGES = {4'h8, 4'h4, 4'h2, 4'h0},
    parameter logic [31:0] RDATA_DEF = RDATA_DEF_C
) (
    input logic HCLK,
    input logic HRESETn,
    ahbl_splitter_n_if.slave bus
);
    logic [NS-1:0] hsel;
    logic miss;
    logic [NS:0] sel_d;
    logic ds_ready, ds_resp;
    logic unused_bits;
    assign unused_bits = ^{bus.HADDR[31-PAGE_W:0], bus.HTRANS[0]};
    always_comb begin
        hsel = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (bus.HADDR[31 -: PAGE_W] == PAGES[i*PAGE_W +: PAGE_W]) begin
                hsel = '0;
                hsel[i] = 1'b1;
            end
    end
    assign miss = ~|hsel;
    assign bus.S_HSEL = hsel;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sel_d <= '0;
        else if (bus.HREADY) sel_d <= bus.HTRANS[1] ? {miss, hsel} : '0;
    end
    ahbl_splitter_n_default_slave u_def (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .sel(miss & bus.HTRANS[1]),
        .HREADY(bus.HREADY),
        .HREADYOUT(ds_ready),
        .HRESP(ds_resp)
    );
    always_comb begin
        bus.HREADY = sel_d[NS] ? ds_ready : 1'b1;
        bus.HRESP = sel_d[NS] ? ds_resp : HRESP_OKAY;
        bus.HRDATA = RDATA_DEF;
        for (int i = 0; i < NS; i++)
            if (sel_d[i]) begin
                bus.HREADY = bus.S_HREADYOUT[i];
                bus.HRESP = bus.S_HRESP[i];
                bus.HRDATA = bus.S_HRDATA[i*32 +: 32];
            end
    end
endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb_ahbl_splitter_n: directed stimulus with scoreboard-checked data-phase responses
module tb_ahbl_splitter_n;
    import ahbl_splitter_n_pkg::*;
    typedef struct {int waits; logic resp; logic [31:0] data;} exp_t;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;
    ahbl_splitter_n_if #(.NS(4)) bus();
    ahbl_splitter_n #(.NS(4)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave));
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask
    // Bench slaves latch the current config when their address phase is accepted
    int cfg_waits = 0;
    logic cfg_err = 1'b0;
    logic [31:0] cfg_data = '0;
    logic rnd_mode = 1'b0;
    logic [3:0] rnd_rdy = '0, rnd_rsp = '0;
    logic [3:0] act;
    logic [3:0] err;
    int cnt[4];
    logic [31:0] dat[4];
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) act <= '0;
        else
            for (int i = 0; i < 4; i++)
                if (bus.HREADY) begin
                    act[i] <= bus.S_HSEL[i] & bus.HTRANS[1];
                    cnt[i] <= cfg_err ? 1 : cfg_waits;
                    err[i] <= cfg_err;
                    dat[i] <= cfg_data;
                end else if (act[i] && cnt[i] != 0) cnt[i] <= cnt[i] - 1;
    end
    always_comb begin
        bus.S_HREADYOUT = '0;
        bus.S_HRESP = '0;
        bus.S_HRDATA = '0;
        for (int i = 0; i < 4; i++) begin
            bus.S_HREADYOUT[i] = rnd_mode ? rnd_rdy[i] : (!act[i] || cnt[i] == 0);
            bus.S_HRESP[i] = rnd_mode ? rnd_rsp[i] : (act[i] && err[i]);
            bus.S_HRDATA[i*32 +: 32] = act[i] ? dat[i] : 32'hDEAD_0000 + 32'(i);
        end
    end
    logic dp = 1'b0;
    logic wresp = 1'b0;
    int wc = 0;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp = 1'b0;
            wc = 0;
            sb.delete();
        end else begin
            if (dp) begin
                if (!bus.HREADY) begin
                    wc++;
                    wresp = bus.HRESP;
                    if (wc == 50) begin
                        checks++;
                        errors++;
                        $display("FAIL wait_timeout actual %0d cycles required completion", wc);
                    end
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response actual HRDATA %h required no data phase", bus.HRDATA);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("waits", wc, e.waits);
                    check("hresp", {31'b0, bus.HRESP}, {31'b0, e.resp});
                    check("hrdata", bus.HRDATA, e.data);
                    if (e.waits > 0) check("wait_hresp", {31'b0, wresp}, {31'b0, e.resp});
                    wc = 0;
                end
            end else begin
                check("idle_hready", {31'b0, bus.HREADY}, 32'd1);
                check("idle_hresp", {31'b0, bus.HRESP}, 32'd0);
            end
            dp = bus.HREADY ? bus.HTRANS[1] : dp;
        end
    end
    task automatic issue(input logic [31:0] a, input logic [1:0] t, input logic [3:0] sel_exp,
                         input int w, input logic e, input logic [31:0] d,
                         input int xw, input logic xr, input logic [31:0] xd);
        int n;
        exp_t x;
        n = 0;
        bus.HADDR = a;
        bus.HTRANS = t;
        cfg_waits = w;
        cfg_err = e;
        cfg_data = d;
        #1 check("s_hsel", {28'b0, bus.S_HSEL}, {28'b0, sel_exp});
        @(negedge HCLK);
        while (!bus.HREADY && n < 50) begin
            n++;
            @(negedge HCLK);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual HREADY low %0d cycles required high", n);
        end
        @(posedge HCLK);
        if (t[1]) begin
            x.waits = xw;
            x.resp = xr;
            x.data = xd;
            sb.push_back(x);
        end
        #1;
    endtask
    task automatic idle();
        issue(32'h3000_0000, HTRANS_IDLE, 4'b0000, 0, 1'b0, '0, 0, 1'b0, '0);
    endtask
    task automatic reset_pulse();
        #1 HRESETn = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        #1;
        check("rst_hready", {31'b0, bus.HREADY}, 32'd1);
        check("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'hBADDBEEF);
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout actual no finish required finish");
        $fatal(1, "timeout");
    end
    initial begin
        rnd_mode = 1'b1;
        bus.HADDR = 32'h8000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        #1 check("rst_s_hsel", {28'b0, bus.S_HSEL}, 32'h8);
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            bus.HADDR = $urandom;
            bus.HTRANS = 2'($urandom_range(0, 3));
            rnd_rdy = 4'($urandom);
            rnd_rsp = 4'($urandom);
            #1;
            check("rst_hready", {31'b0, bus.HREADY}, 32'd1);
            check("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
            check("rst_hrdata", bus.HRDATA, 32'hBADDBEEF);
        end
        rnd_mode = 1'b0;
        bus.HADDR = '0;
        bus.HTRANS = HTRANS_IDLE;
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        issue(32'h2000_0010, HTRANS_NONSEQ, 4'b0010, 2, 1'b0, 32'h1234_5678, 2, 1'b0, 32'h1234_5678);
        idle();
        issue(32'h3000_0000, HTRANS_NONSEQ, 4'b0000, 0, 1'b0, '0, 1, 1'b1, 32'hBADDBEEF);
        issue(32'h3000_0000, HTRANS_BUSY, 4'b0000, 0, 1'b0, '0, 0, 1'b0, '0);
        idle();
        issue(32'h3000_0000, HTRANS_NONSEQ, 4'b0000, 0, 1'b0, '0, 1, 1'b1, 32'hBADDBEEF);
        issue(32'h5000_0000, HTRANS_SEQ, 4'b0000, 0, 1'b0, '0, 1, 1'b1, 32'hBADDBEEF);
        idle();
        issue(32'h0000_0000, HTRANS_NONSEQ, 4'b0001, 0, 1'b0, 32'hA0A0_0000, 0, 1'b0, 32'hA0A0_0000);
        issue(32'h8000_0004, HTRANS_NONSEQ, 4'b1000, 1, 1'b0, 32'hA3A3_0003, 1, 1'b0, 32'hA3A3_0003);
        issue(32'hF000_0000, HTRANS_NONSEQ, 4'b0000, 0, 1'b0, '0, 1, 1'b1, 32'hBADDBEEF);
        issue(32'h4000_0000, HTRANS_NONSEQ, 4'b0100, 0, 1'b0, 32'hA2A2_0002, 0, 1'b0, 32'hA2A2_0002);
        idle();
        issue(32'h4000_0000, HTRANS_NONSEQ, 4'b0100, 0, 1'b1, 32'h5555_AAAA, 1, 1'b1, 32'h5555_AAAA);
        idle();
        issue(32'h3000_0000, HTRANS_NONSEQ, 4'b0000, 0, 1'b0, '0, 1, 1'b1, 32'hBADDBEEF);
        reset_pulse();
        issue(32'h2000_0000, HTRANS_NONSEQ, 4'b0010, 0, 1'b0, 32'h600D_0001, 0, 1'b0, 32'h600D_0001);
        idle();
        issue(32'h0000_0100, HTRANS_NONSEQ, 4'b0001, 3, 1'b0, 32'h0000_0011, 3, 1'b0, 32'h0000_0011);
        reset_pulse();
        issue(32'h8000_0000, HTRANS_NONSEQ, 4'b1000, 0, 1'b0, 32'h600D_0003, 0, 1'b0, 32'h600D_0003);
        idle();
        repeat (3) @(posedge HCLK);
        #1 check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
